// File: rtl/load_store_unit.sv
// Memory execution unit: pops one ld/st entry, reads the PRF, performs
// the data-memory access and broadcasts the result on the CDB.
package lsu_pkg;
  localparam int NUM_REGS = 64;
  localparam int ROB_SIZE = 32;
  localparam int PHYS_W = $clog2(NUM_REGS);
  localparam int ROB_W = $clog2(ROB_SIZE);

  localparam logic [6:0] op_b_load = 7'b0000011;
  localparam logic [6:0] op_b_store = 7'b0100011;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [31:0] imm;
    logic [PHYS_W-1:0] pr1_s_ld_st;
    logic [PHYS_W-1:0] pr2_s_ld_st;
    logic [PHYS_W-1:0] phys_rd;
    logic [4:0] arch_rd;
    logic [ROB_W-1:0] rob_index;
  } ld_st_queue_t;
endpackage

module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              lsq_empty,
  output logic              lsq_read_enable,
  input  logic              lsq_read_resp,
  input  ld_st_queue_t      lsq_data,
  output logic [PHYS_W-1:0] prf_rs1_addr,
  output logic [PHYS_W-1:0] prf_rs2_addr,
  input  logic [31:0]       prf_rs1_data,
  input  logic [31:0]       prf_rs2_data,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              cdb_valid,
  output logic [PHYS_W-1:0] cdb_phys_rd,
  output logic [4:0]        cdb_arch_rd,
  output logic [ROB_W-1:0]  cdb_rob_index,
  output logic [31:0]       cdb_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL, S_ADDR, S_MEM, S_WB
  } state_t;

  state_t            r_state;
  ld_st_queue_t      r_entry;
  logic [1:0]        r_off;
  logic [31:0]       r_addr;
  logic [3:0]        r_rmask;
  logic [3:0]        r_wmask;
  logic [31:0]       r_wdata;
  logic              r_killed;
  logic              r_cdb_valid;
  logic [PHYS_W-1:0] r_cdb_phys;
  logic [4:0]        r_cdb_arch;
  logic [ROB_W-1:0]  r_cdb_rob;
  logic [31:0]       r_cdb_data;

  logic [31:0] w_ea;
  logic [31:0] w_wdata;
  logic [31:0] w_sh;
  logic [31:0] w_ld;
  logic [3:0]  w_base;
  logic [3:0]  w_mask;
  logic        w_is_store;

  assign lsq_read_enable = (r_state == S_IDLE) & ~lsq_empty
                         & ~flush & ~rst;
  assign prf_rs1_addr = (r_state == S_ADDR) ? r_entry.pr1_s_ld_st : '0;
  assign prf_rs2_addr = (r_state == S_ADDR) ? r_entry.pr2_s_ld_st : '0;

  assign w_is_store = (r_entry.opcode == op_b_store);
  assign w_ea = prf_rs1_data + r_entry.imm;
  assign w_mask = w_base << w_ea[1:0];
  assign w_wdata = prf_rs2_data << {w_ea[1:0], 3'b000};
  assign w_sh = dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_base = 4'b1111;
    unique case (r_entry.funct3)
      3'b000, 3'b100: w_base = 4'b0001;
      3'b001, 3'b101: w_base = 4'b0011;
      default:        w_base = 4'b1111;
    endcase
  end

  always_comb begin
    w_ld = w_sh;
    unique case (r_entry.funct3)
      3'b000:  w_ld = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b100:  w_ld = {24'b0, w_sh[7:0]};
      3'b001:  w_ld = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b101:  w_ld = {16'b0, w_sh[15:0]};
      default: w_ld = w_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_entry     <= '0;
      r_off       <= '0;
      r_addr      <= '0;
      r_rmask     <= '0;
      r_wmask     <= '0;
      r_wdata     <= '0;
      r_killed    <= 1'b0;
      r_cdb_valid <= 1'b0;
      r_cdb_phys  <= '0;
      r_cdb_arch  <= '0;
      r_cdb_rob   <= '0;
      r_cdb_data  <= '0;
    end else begin
      r_cdb_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (~lsq_empty & ~flush) r_state <= S_POLL;
        end
        S_POLL: begin
          if (lsq_read_resp & ~flush) begin
            r_entry <= lsq_data;
            r_state <= S_ADDR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ADDR: begin
          if (flush) begin
            r_entry <= '0;
            r_state <= S_IDLE;
          end else begin
            r_addr  <= {w_ea[31:2], 2'b00};
            r_off   <= w_ea[1:0];
            r_rmask <= w_is_store ? 4'b0 : w_mask;
            r_wmask <= w_is_store ? w_mask : 4'b0;
            r_wdata <= w_is_store ? w_wdata : 32'b0;
            r_state <= S_MEM;
          end
        end
        S_MEM: begin
          // the cache cannot abort, so a flush only marks the access dead
          if (flush) r_killed <= 1'b1;
          if (dmem_resp) begin
            r_addr   <= '0;
            r_rmask  <= '0;
            r_wmask  <= '0;
            r_wdata  <= '0;
            r_killed <= 1'b0;
            if (r_killed | flush) begin
              r_state <= S_IDLE;
            end else begin
              r_state     <= S_WB;
              r_cdb_valid <= 1'b1;
              r_cdb_rob   <= r_entry.rob_index;
              r_cdb_phys  <= w_is_store ? '0 : r_entry.phys_rd;
              r_cdb_arch  <= w_is_store ? '0 : r_entry.arch_rd;
              r_cdb_data  <= w_is_store ? '0 : w_ld;
            end
          end
        end
        S_WB: begin
          r_state    <= S_IDLE;
          r_cdb_phys <= '0;
          r_cdb_arch <= '0;
          r_cdb_rob  <= '0;
          r_cdb_data <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem_addr     = r_addr;
  assign dmem_rmask    = r_rmask;
  assign dmem_wmask    = r_wmask;
  assign dmem_wdata    = r_wdata;
  assign cdb_valid     = r_cdb_valid & ~flush;
  assign cdb_phys_rd   = r_cdb_phys;
  assign cdb_arch_rd   = r_cdb_arch;
  assign cdb_rob_index = r_cdb_rob;
  assign cdb_data      = r_cdb_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with queue, PRF and memory models.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, lsq_empty, lsq_read_enable, lsq_read_resp;
  ld_st_queue_t lsq_data;
  logic [PHYS_W-1:0] prf_rs1_addr, prf_rs2_addr;
  logic [31:0] prf_rs1_data, prf_rs2_data;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0] dmem_rmask, dmem_wmask;
  logic dmem_resp, cdb_valid;
  logic [PHYS_W-1:0] cdb_phys_rd;
  logic [4:0] cdb_arch_rd;
  logic [ROB_W-1:0] cdb_rob_index;
  logic [31:0] cdb_data;

  load_store_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lsq_empty(lsq_empty), .lsq_read_enable(lsq_read_enable),
    .lsq_read_resp(lsq_read_resp), .lsq_data(lsq_data),
    .prf_rs1_addr(prf_rs1_addr), .prf_rs2_addr(prf_rs2_addr),
    .prf_rs1_data(prf_rs1_data), .prf_rs2_data(prf_rs2_data),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .cdb_valid(cdb_valid), .cdb_phys_rd(cdb_phys_rd),
    .cdb_arch_rd(cdb_arch_rd), .cdb_rob_index(cdb_rob_index),
    .cdb_data(cdb_data)
  );

  logic [31:0] prf [NUM_REGS];
  logic [31:0] mem [logic [31:0]];
  ld_st_queue_t q_tab [8];

  assign prf_rs1_data = prf[prf_rs1_addr];
  assign prf_rs2_data = prf[prf_rs2_addr];

  int posted, delivered, pops, declines_done, decl_total;
  int dmem_delay, wait_cnt, consec, cyc, en_cyc;
  int cdb_cnt, c_cyc, c_cyc_prev, req_cnt, hold, unstable;
  int n_vec, n_bad;
  bit en_s, en_prev, in_req;
  logic [31:0] c_data, c_data_prev, s_addr, s_wdata;
  logic [3:0] s_rmask, s_wmask;
  logic [PHYS_W-1:0] c_phys;
  logic [4:0] c_arch;
  logic [ROB_W-1:0] c_rob;

  always @(posedge clk) cyc <= cyc + 1;

  // observe outputs mid-cycle
  always @(negedge clk) begin
    en_s = lsq_read_enable;
    if (lsq_read_enable) begin
      pops++;
      en_cyc = cyc;
      if (en_prev) consec++;
    end
    en_prev = lsq_read_enable;
    if (cdb_valid) begin
      cdb_cnt++;
      c_cyc_prev = c_cyc;
      c_cyc = cyc;
      c_data_prev = c_data;
      c_data = cdb_data;
      c_phys = cdb_phys_rd;
      c_arch = cdb_arch_rd;
      c_rob = cdb_rob_index;
    end
    if ((dmem_rmask | dmem_wmask) != 4'b0) begin
      if (!in_req) begin
        req_cnt++;
        s_addr = dmem_addr;
        s_rmask = dmem_rmask;
        s_wmask = dmem_wmask;
        s_wdata = dmem_wdata;
        hold = 1;
        unstable = 0;
      end else begin
        hold++;
        if (dmem_addr !== s_addr || dmem_rmask !== s_rmask ||
            dmem_wmask !== s_wmask || dmem_wdata !== s_wdata)
          unstable++;
      end
      in_req = 1'b1;
    end else begin
      in_req = 1'b0;
    end
  end

  // queue and memory responders
  initial begin
    lsq_read_resp = 1'b0;
    lsq_data = '0;
    lsq_empty = 1'b1;
    dmem_resp = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      lsq_read_resp = 1'b0;
      if (en_s) begin
        if (declines_done < decl_total) begin
          declines_done++;
        end else begin
          lsq_read_resp = 1'b1;
          lsq_data = q_tab[delivered[2:0]];
          delivered++;
        end
      end
      lsq_empty = (delivered >= posted);
      dmem_resp = 1'b0;
      if ((dmem_rmask | dmem_wmask) != 4'b0) begin
        if (wait_cnt >= dmem_delay) begin
          dmem_resp = 1'b1;
          dmem_rdata = mem.exists(dmem_addr) ? mem[dmem_addr] : 32'h0;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  function automatic ld_st_queue_t mk(input logic [6:0] op,
      input logic [2:0] f3, input logic [31:0] imm, input int pr1,
      input int pr2, input int prd, input int ard, input int rob);
    ld_st_queue_t e;
    e.opcode = op;
    e.funct3 = f3;
    e.imm = imm;
    e.pr1_s_ld_st = PHYS_W'(pr1);
    e.pr2_s_ld_st = PHYS_W'(pr2);
    e.phys_rd = PHYS_W'(prd);
    e.arch_rd = 5'(ard);
    e.rob_index = ROB_W'(rob);
    return e;
  endfunction

  task automatic post(input ld_st_queue_t e);
    q_tab[posted[2:0]] = e;
    posted++;
  endtask

  task automatic wait_cdb(input int target, output bit ok);
    int t = 0;
    while (cdb_cnt < target && t < 60) begin
      @(negedge clk);
      #2;
      t++;
    end
    ok = (cdb_cnt >= target);
    repeat (3) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    flush = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    n_vec++; if (lsq_read_enable !== 1'b0) begin n_bad++;
      $display("FAIL rst_en got %b want 0", lsq_read_enable); end
    n_vec++; if (dmem_rmask !== 4'h0 || dmem_wmask !== 4'h0) begin n_bad++;
      $display("FAIL rst_mask got %h/%h want 0/0", dmem_rmask, dmem_wmask); end
    n_vec++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin n_bad++;
      $display("FAIL rst_addr got %h/%h want 0/0", dmem_addr, dmem_wdata); end
    n_vec++; if (cdb_valid !== 1'b0) begin n_bad++;
      $display("FAIL rst_cdb_valid got %b want 0", cdb_valid); end
    n_vec++; if (cdb_data !== 32'h0 || cdb_rob_index !== '0) begin n_bad++;
      $display("FAIL rst_cdb got %h/%h want 0/0", cdb_data, cdb_rob_index); end
    n_vec++; if (cdb_phys_rd !== '0 || cdb_arch_rd !== '0) begin n_bad++;
      $display("FAIL rst_cdb_rd got %h/%h want 0/0", cdb_phys_rd, cdb_arch_rd); end
    n_vec++; if (prf_rs1_addr !== '0 || prf_rs2_addr !== '0) begin n_bad++;
      $display("FAIL rst_prf got %h/%h want 0/0", prf_rs1_addr, prf_rs2_addr); end
    rst = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    n_vec++; if (lsq_read_enable !== 1'b0) begin n_bad++;
      $display("FAIL empty_en got %b want 0", lsq_read_enable); end
  endtask

  task automatic test_load_lhu;
    int c0 = cdb_cnt;
    int r0 = req_cnt;
    bit ok;
    prf[3] = 32'h0000_1000;
    mem[32'h1004] = 32'hBEEF_1234;
    post(mk(op_b_load, 3'b101, 32'd6, 3, 0, 9, 5, 7));
    wait_cdb(c0 + 1, ok);
    n_vec++; if (!ok) begin n_bad++;
      $display("FAIL lhu_timeout got %0d pulses want 1", cdb_cnt - c0); end
    n_vec++; if (req_cnt - r0 !== 1) begin n_bad++;
      $display("FAIL lhu_reqs got %0d want 1", req_cnt - r0); end
    n_vec++; if (s_addr !== 32'h1004) begin n_bad++;
      $display("FAIL lhu_addr got %h want 00001004", s_addr); end
    n_vec++; if (s_rmask !== 4'b1100 || s_wmask !== 4'b0000) begin n_bad++;
      $display("FAIL lhu_mask got %b/%b want 1100/0000", s_rmask, s_wmask); end
    n_vec++; if (c_data !== 32'h0000_BEEF) begin n_bad++;
      $display("FAIL lhu_data got %h want 0000beef", c_data); end
    n_vec++; if (c_phys !== 6'd9 || c_arch !== 5'd5 || c_rob !== 5'd7) begin
      n_bad++;
      $display("FAIL lhu_tags got %0d/%0d/%0d want 9/5/7",
               c_phys, c_arch, c_rob); end
    n_vec++; if (cdb_cnt - c0 !== 1) begin n_bad++;
      $display("FAIL lhu_pulse got %0d want 1", cdb_cnt - c0); end
    n_vec++; if (c_cyc - en_cyc !== 4) begin n_bad++;
      $display("FAIL lhu_latency got %0d want 4", c_cyc - en_cyc); end
  endtask

  task automatic test_store_sb;
    int c0 = cdb_cnt;
    bit ok;
    prf[4] = 32'h0000_2003;
    prf[5] = 32'h0000_00A5;
    post(mk(op_b_store, 3'b000, 32'd0, 4, 5, 12, 3, 11));
    wait_cdb(c0 + 1, ok);
    n_vec++; if (!ok) begin n_bad++;
      $display("FAIL sb_timeout got %0d pulses want 1", cdb_cnt - c0); end
    n_vec++; if (s_addr !== 32'h2000) begin n_bad++;
      $display("FAIL sb_addr got %h want 00002000", s_addr); end
    n_vec++; if (s_wmask !== 4'b1000 || s_rmask !== 4'b0000) begin n_bad++;
      $display("FAIL sb_mask got %b/%b want 1000/0000", s_wmask, s_rmask); end
    n_vec++; if (s_wdata !== 32'hA500_0000) begin n_bad++;
      $display("FAIL sb_wdata got %h want a5000000", s_wdata); end
    n_vec++; if (c_phys !== '0 || c_arch !== '0 || c_data !== 32'h0) begin
      n_bad++;
      $display("FAIL sb_cdb got %0d/%0d/%h want 0/0/0",
               c_phys, c_arch, c_data); end
    n_vec++; if (c_rob !== 5'd11) begin n_bad++;
      $display("FAIL sb_rob got %0d want 11", c_rob); end
  endtask

  task automatic test_decline;
    int c0 = cdb_cnt;
    int p0 = pops;
    int d0 = delivered;
    int k0 = consec;
    bit ok;
    decl_total += 3;
    prf[6] = 32'h0000_3000;
    mem[32'h3008] = 32'h1234_5678;
    post(mk(op_b_load, 3'b010, 32'd8, 6, 0, 20, 10, 2));
    wait_cdb(c0 + 1, ok);
    n_vec++; if (!ok) begin n_bad++;
      $display("FAIL decl_timeout got %0d pulses want 1", cdb_cnt - c0); end
    n_vec++; if (pops - p0 !== 4) begin n_bad++;
      $display("FAIL decl_pops got %0d want 4", pops - p0); end
    n_vec++; if (delivered - d0 !== 1) begin n_bad++;
      $display("FAIL decl_captures got %0d want 1", delivered - d0); end
    n_vec++; if (consec !== k0) begin n_bad++;
      $display("FAIL decl_consec got %0d want %0d", consec, k0); end
    n_vec++; if (s_addr !== 32'h3008 || s_rmask !== 4'b1111) begin n_bad++;
      $display("FAIL decl_req got %h/%b want 00003008/1111",
               s_addr, s_rmask); end
    n_vec++; if (c_data !== 32'h1234_5678 || c_rob !== 5'd2) begin n_bad++;
      $display("FAIL decl_cdb got %h/%0d want 12345678/2", c_data, c_rob); end
  endtask

  task automatic test_sign_ext;
    int c0 = cdb_cnt;
    bit ok;
    prf[7] = 32'h0000_4001;
    prf[8] = 32'h0000_5000;
    mem[32'h4000] = 32'h1122_8033;
    mem[32'h5000] = 32'h8001_7F7F;
    post(mk(op_b_load, 3'b000, 32'd0, 7, 0, 21, 1, 3));
    wait_cdb(c0 + 1, ok);
    n_vec++; if (!ok || c_data !== 32'hFFFF_FF80) begin n_bad++;
      $display("FAIL lb_data got %h want ffffff80", c_data); end
    n_vec++; if (s_rmask !== 4'b0010) begin n_bad++;
      $display("FAIL lb_mask got %b want 0010", s_rmask); end
    post(mk(op_b_load, 3'b100, 32'd0, 7, 0, 22, 2, 4));
    wait_cdb(c0 + 2, ok);
    n_vec++; if (!ok || c_data !== 32'h0000_0080) begin n_bad++;
      $display("FAIL lbu_data got %h want 00000080", c_data); end
    post(mk(op_b_load, 3'b001, 32'd2, 8, 0, 23, 3, 5));
    wait_cdb(c0 + 3, ok);
    n_vec++; if (!ok || c_data !== 32'hFFFF_8001) begin n_bad++;
      $display("FAIL lh_data got %h want ffff8001", c_data); end
    n_vec++; if (s_rmask !== 4'b1100 || s_addr !== 32'h5000) begin n_bad++;
      $display("FAIL lh_req got %b/%h want 1100/00005000", s_rmask, s_addr); end
  endtask

  task automatic test_flush_mem;
    int c0 = cdb_cnt;
    int r0 = req_cnt;
    int t = 0;
    bit ok;
    dmem_delay = 4;
    prf[9] = 32'h0000_6000;
    mem[32'h6000] = 32'hCAFE_F00D;
    mem[32'h6004] = 32'h0BAD_BEEF;
    post(mk(op_b_load, 3'b010, 32'd0, 9, 0, 24, 4, 8));
    while (!in_req && t < 40) begin
      @(negedge clk);
      #2;
      t++;
    end
    n_vec++; if (!in_req) begin n_bad++;
      $display("FAIL flush_req_timeout got no request want request"); end
    flush = 1'b1;
    @(negedge clk);
    #2;
    flush = 1'b0;
    t = 0;
    while (in_req && t < 20) begin
      @(negedge clk);
      #2;
      t++;
    end
    repeat (3) begin
      @(negedge clk);
      #2;
    end
    n_vec++; if (hold !== 5 || unstable !== 0) begin n_bad++;
      $display("FAIL flush_hold got %0d/%0d want 5/0", hold, unstable); end
    n_vec++; if (cdb_cnt !== c0) begin n_bad++;
      $display("FAIL flush_cdb got %0d pulses want 0", cdb_cnt - c0); end
    n_vec++; if (req_cnt - r0 !== 1 || dmem_rmask !== 4'b0) begin n_bad++;
      $display("FAIL flush_idle got %0d/%b want 1/0000",
               req_cnt - r0, dmem_rmask); end
    dmem_delay = 0;
    post(mk(op_b_load, 3'b010, 32'd4, 9, 0, 25, 6, 9));
    wait_cdb(c0 + 1, ok);
    n_vec++; if (!ok || c_data !== 32'h0BAD_BEEF || c_rob !== 5'd9) begin
      n_bad++;
      $display("FAIL after_flush got %h/%0d want 0badbeef/9", c_data, c_rob);
    end
  endtask

  task automatic test_back_to_back;
    int c0 = cdb_cnt;
    int k0 = consec;
    bit ok;
    prf[10] = 32'h0000_7000;
    mem[32'h7000] = 32'h1111_1111;
    mem[32'h7004] = 32'h2222_2222;
    post(mk(op_b_load, 3'b010, 32'd0, 10, 0, 26, 7, 12));
    post(mk(op_b_load, 3'b010, 32'd4, 10, 0, 27, 8, 13));
    wait_cdb(c0 + 2, ok);
    n_vec++; if (!ok || cdb_cnt - c0 !== 2) begin n_bad++;
      $display("FAIL b2b_pulses got %0d want 2", cdb_cnt - c0); end
    n_vec++; if (c_cyc - c_cyc_prev !== 5) begin n_bad++;
      $display("FAIL b2b_gap got %0d want 5", c_cyc - c_cyc_prev); end
    n_vec++; if (c_data_prev !== 32'h1111_1111 || c_data !== 32'h2222_2222)
    begin n_bad++;
      $display("FAIL b2b_data got %h/%h want 11111111/22222222",
               c_data_prev, c_data); end
    n_vec++; if (c_rob !== 5'd13 || consec !== k0) begin n_bad++;
      $display("FAIL b2b_rob got %0d/%0d want 13/%0d", c_rob, consec, k0); end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) prf[i] = 32'h0;
    test_reset();
    test_load_lhu();
    test_store_sb();
    test_decline();
    test_sign_ext();
    test_flush_mem();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
